// File: rtl/btn_press_cond.sv
// Push-button conditioner: per-button 2-FF synchroniser, tick-sampled debounce FSM,
// one-CLK press strobe and optional hold auto-repeat, sharing one sample prescaler.
module btn_press_cond #(
    parameter int unsigned N_BTN         = 2,
    parameter int unsigned TICK_DIV      = 125000,
    parameter int unsigned DEB_SAMPLES   = 8,
    parameter int unsigned REPEAT_EN     = 1,
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 100
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTNIN,
    output logic [N_BTN-1:0] BTNOUT,
    output logic [N_BTN-1:0] LEVEL
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CMP_MAX =
        (DEB_SAMPLES > REPEAT_DELAY)
            ? ((DEB_SAMPLES > REPEAT_PERIOD) ? DEB_SAMPLES : REPEAT_PERIOD)
            : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int unsigned CW = (CMP_MAX > 1) ? $clog2(CMP_MAX) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_SAMPLES - 1);
    localparam logic [CW-1:0] DLY_LAST   = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST   = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam bit            RPT        = (REPEAT_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_CHK,
        ST_HELD,
        ST_REPEAT,
        ST_REL_CHK
    } state_t;

    logic [PW-1:0]    r_presc;
    logic             w_tick;
    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    assign w_tick = (r_presc == PRESC_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= BTNIN;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic          r_level;
        logic          w_level_nxt;
        logic          r_out;
        logic          w_strobe;
        logic          w_s;

        assign w_s = r_sync2[g];

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_out   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_level <= w_level_nxt;
                r_out   <= w_strobe;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_level_nxt = r_level;
            w_strobe    = 1'b0;
            if (w_tick) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_s) begin
                            w_state_nxt = ST_PRESS_CHK;
                            w_cnt_nxt   = CNT_ONE;
                        end
                    end
                    ST_PRESS_CHK: begin
                        if (!w_s) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == DEB_LAST) begin
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = '0;
                            w_level_nxt = 1'b1;
                            w_strobe    = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                    ST_HELD: begin
                        if (!w_s) begin
                            w_state_nxt = ST_REL_CHK;
                            w_cnt_nxt   = CNT_ONE;
                        end else if (RPT && r_cnt == DLY_LAST) begin
                            w_state_nxt = ST_REPEAT;
                            w_cnt_nxt   = '0;
                            w_strobe    = 1'b1;
                        end else if (RPT || r_cnt != '1) begin
                            // without repeat the hold count just saturates
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                    ST_REPEAT: begin
                        if (!w_s) begin
                            w_state_nxt = ST_REL_CHK;
                            w_cnt_nxt   = CNT_ONE;
                        end else if (r_cnt == PER_LAST) begin
                            w_cnt_nxt = '0;
                            w_strobe  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                    ST_REL_CHK: begin
                        if (w_s) begin
                            w_state_nxt = ST_HELD;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == DEB_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = '0;
                            w_level_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_level_nxt = 1'b0;
                    end
                endcase
            end
        end

        assign BTNOUT[g] = r_out;
        assign LEVEL[g]  = r_level;
    end

endmodule

// File: tb/tb_btn_press_cond.sv
// Scoreboard bench for btn_press_cond: two instances (repeat off / on), expected
// strobes queued by the stimulus and matched by per-instance monitors.
module tb_btn_press_cond;

    typedef struct {
        bit         rel;   // 1: lo is exact distance from previous pulse
        int         lo;
        int         hi;
        logic [1:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] bt0, bt1;
    logic [1:0] out0, out1;
    logic [1:0] lvl0, lvl1;

    int   cyc;
    int   n_chk;
    int   n_pass;
    int   last0, last1;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    btn_press_cond #(
        .N_BTN(2), .TICK_DIV(4), .DEB_SAMPLES(3), .REPEAT_EN(0),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut0 (
        .CLK(clk), .RST(rst), .BTNIN(bt0), .BTNOUT(out0), .LEVEL(lvl0)
    );

    btn_press_cond #(
        .N_BTN(2), .TICK_DIV(4), .DEB_SAMPLES(3), .REPEAT_EN(1),
        .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
    ) dut1 (
        .CLK(clk), .RST(rst), .BTNIN(bt1), .BTNOUT(out1), .LEVEL(lvl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic chk_lvl(input string name, input logic [1:0] act, input logic [1:0] exp);
        check(name, act === exp, $sformatf("LEVEL=%b required %b at cyc %0d", act, exp, cyc));
    endtask

    task automatic mon_cmp(input string name, input exp_t e, input logic [1:0] v,
                           input int c, input int last);
        bit ok;
        if (e.rel) begin
            ok = (c - last == e.lo) && (v === e.val);
            check(name, ok, $sformatf("pulse %b at +%0d, required %b at +%0d",
                                      v, c - last, e.val, e.lo));
        end else begin
            ok = (c >= e.lo) && (c <= e.hi) && (v === e.val);
            check(name, ok, $sformatf("pulse %b at cyc %0d, required %b in [%0d,%0d]",
                                      v, c, e.val, e.lo, e.hi));
        end
    endtask

    always @(negedge clk) begin
        if (out0 !== 2'b00) begin
            if (q0.size() == 0) begin
                check("dut0_pulse", 1'b0, $sformatf("pulse %b at cyc %0d, required none", out0, cyc));
            end else begin
                e0 = q0.pop_front();
                mon_cmp("dut0_pulse", e0, out0, cyc, last0);
            end
            last0 = cyc;
        end
    end

    always @(negedge clk) begin
        if (out1 !== 2'b00) begin
            if (q1.size() == 0) begin
                check("dut1_pulse", 1'b0, $sformatf("pulse %b at cyc %0d, required none", out1, cyc));
            end else begin
                e1 = q1.pop_front();
                mon_cmp("dut1_pulse", e1, out1, cyc, last1);
            end
            last1 = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input bit rel, input int lo, input int hi, input logic [1:0] v);
        exp_t e;
        e.rel = rel; e.lo = lo; e.hi = hi; e.val = v;
        return e;
    endfunction

    initial begin
        n_chk = 0; n_pass = 0; last0 = 0; last1 = 0;
        rst = 1'b1; bt0 = 2'b00; bt1 = 2'b00;
        step(3);
        chk_lvl("rst_lvl0", lvl0, 2'b00);
        chk_lvl("rst_lvl1", lvl1, 2'b00);
        check("rst_out", (out0 === 2'b00) && (out1 === 2'b00),
              $sformatf("BTNOUT=%b/%b required 00/00", out0, out1));
        rst = 1'b0;
        step(2);

        // 1: single press, no repeat, clean release
        bt0[0] = 1'b1;
        q0.push_back(mk(1'b0, cyc + 11, cyc + 15, 2'b01));
        step(100);
        chk_lvl("t1_lvl_held", lvl0, 2'b01);
        step(100);
        bt0[0] = 1'b0;
        step(10);
        chk_lvl("t1_lvl_before_fall", lvl0, 2'b01);
        step(5);
        chk_lvl("t1_lvl_fallen", lvl0, 2'b00);
        step(20);

        // 2: bounce every 3 cycles, then stable high
        for (int i = 0; i < 20; i++) begin
            bt0[0] = (i % 2 == 0);
            step(3);
        end
        chk_lvl("t2_lvl_bounce", lvl0, 2'b00);
        bt0[0] = 1'b1;
        q0.push_back(mk(1'b0, cyc + 3, cyc + 15, 2'b01));
        step(30);
        chk_lvl("t2_lvl_held", lvl0, 2'b01);
        bt0[0] = 1'b0;
        step(20);
        chk_lvl("t2_lvl_rel", lvl0, 2'b00);

        // 3: glitch too short to be accepted
        bt0[1] = 1'b1;
        step(6);
        bt0[1] = 1'b0;
        step(4);
        chk_lvl("t3_lvl_a", lvl0, 2'b00);
        step(16);
        chk_lvl("t3_lvl_b", lvl0, 2'b00);

        // 4: auto-repeat while held for 200 cycles
        bt1[0] = 1'b1;
        q1.push_back(mk(1'b0, cyc + 11, cyc + 15, 2'b01));
        q1.push_back(mk(1'b1, 32, 32, 2'b01));
        for (int i = 0; i < 9; i++) q1.push_back(mk(1'b1, 16, 16, 2'b01));
        step(200);
        chk_lvl("t4_lvl_held", lvl1, 2'b01);
        bt1[0] = 1'b0;
        step(10);
        chk_lvl("t4_lvl_before_fall", lvl1, 2'b01);
        step(5);
        chk_lvl("t4_lvl_fallen", lvl1, 2'b00);
        step(40);

        // 5: both buttons pressed in the same cycle
        bt0 = 2'b11;
        q0.push_back(mk(1'b0, cyc + 11, cyc + 15, 2'b11));
        step(20);
        chk_lvl("t5_lvl_both", lvl0, 2'b11);

        // 6: reset while button 0 is held
        bt0 = 2'b01;
        step(20);
        chk_lvl("t6_lvl_pre", lvl0, 2'b01);
        rst = 1'b1;
        step(1);
        chk_lvl("t6_lvl_rst", lvl0, 2'b00);
        check("t6_out_rst", out0 === 2'b00, $sformatf("BTNOUT=%b required 00", out0));
        step(2);
        rst = 1'b0;
        q0.push_back(mk(1'b0, cyc + 12, cyc + 15, 2'b01));
        step(30);
        chk_lvl("t6_lvl_reacq", lvl0, 2'b01);
        bt0 = 2'b00;
        step(30);

        check("dut0_drain", q0.size() == 0, $sformatf("%0d pulses missing, required 0", q0.size()));
        check("dut1_drain", q1.size() == 0, $sformatf("%0d pulses missing, required 0", q1.size()));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
